// File: rtl/fetch_align_buffer_if.sv
// Handshake bundle between memory, the fetch align buffer and decode.
// slave is the buffer's own view; master is the driving side.
interface fetch_align_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_c;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport slave (
    input  in_valid, in_word, out_ready,
    input  redirect, redirect_pc,
    output in_ready, out_valid, out_instr,
    output out_pc, out_is_c
  );

  modport master (
    output in_valid, in_word, out_ready,
    output redirect, redirect_pc,
    input  in_ready, out_valid, out_instr,
    input  out_pc, out_is_c
  );
endinterface

// File: rtl/fetch_align_buffer.sv
// Halfword FIFO realigning memory words into RV32I(MC) instructions.
// FETCH_COMPRESSED_EN enables 16-bit instruction support.
module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          HW_DEPTH = 4
) (
  input logic clk,
  input logic nrst,
  fetch_align_buffer_if.slave bus
);
  localparam int PW = $clog2(HW_DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem_q [HW_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   pc_q, pc_d;
  logic          skip_q, skip_d;

  logic          we0, we1;
  logic [PW-1:0] wa0, wa1;
  logic [15:0]   wd0, wd1;
  logic [15:0]   head, nxt;
  logic          is_c, valid, push, pop;
  logic [CW-1:0] n_push, n_pop;
  logic [31:0]   rpc_al;
  logic          rskip;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [1:0]    k
  );
    int s;
    s = int'(p) + int'(k);
    if (s >= HW_DEPTH) s = s - HW_DEPTH;
    return PW'(s);
  endfunction

  assign head = mem_q[rd_q];
  assign nxt  = mem_q[wrap(rd_q, 2'd1)];

`ifdef FETCH_COMPRESSED_EN
  logic unused_rpc;
  assign unused_rpc = bus.redirect_pc[0];
  assign is_c   = head[1:0] != 2'b11;
  assign rpc_al = {bus.redirect_pc[31:1], 1'b0};
  assign rskip  = bus.redirect_pc[1];
`else
  logic [1:0] unused_rpc;
  assign unused_rpc = bus.redirect_pc[1:0];
  assign is_c   = 1'b0;
  assign rpc_al = {bus.redirect_pc[31:2], 2'b00};
  assign rskip  = 1'b0;
`endif

  assign valid = is_c ? (cnt_q >= CW'(1))
                      : (cnt_q >= CW'(2));
  assign bus.in_ready = cnt_q <= CW'(HW_DEPTH - 2);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = valid && bus.out_ready;

  assign bus.out_valid = valid;
  assign bus.out_is_c  = valid && is_c;
  assign bus.out_pc    = pc_q;
  assign bus.out_instr = !valid ? 32'h0 :
                         is_c   ? {16'h0, head} :
                                  {nxt, head};

  always_comb begin
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    pc_d   = pc_q;
    skip_d = skip_q;
    we0    = 1'b0;
    we1    = 1'b0;
    wa0    = wr_q;
    wa1    = wrap(wr_q, 2'd1);
    wd0    = bus.in_word[15:0];
    wd1    = bus.in_word[31:16];
    n_push = '0;
    n_pop  = '0;
    if (bus.redirect) begin
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
      pc_d   = rpc_al;
      skip_d = rskip;
    end else begin
      unique case (1'b1)
        push && skip_q: begin
          we0    = 1'b1;
          wd0    = bus.in_word[31:16];
          wr_d   = wrap(wr_q, 2'd1);
          skip_d = 1'b0;
          n_push = CW'(1);
        end
        push && !skip_q: begin
          we0    = 1'b1;
          we1    = 1'b1;
          wr_d   = wrap(wr_q, 2'd2);
          n_push = CW'(2);
        end
        default: ;
      endcase
      if (pop) begin
        rd_d  = wrap(rd_q, is_c ? 2'd1 : 2'd2);
        pc_d  = pc_q + (is_c ? 32'd2 : 32'd4);
        n_pop = is_c ? CW'(1) : CW'(2);
      end
      cnt_d = cnt_q + n_push - n_pop;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      pc_q   <= RESET_PC;
      skip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < HW_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (we0) mem_q[wa0] <= wd0;
      if (we1) mem_q[wa1] <= wd1;
    end
  end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer in either build flavour.
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_fetch_align_buffer;
  logic clk;
  logic nrst;
  int   cmp;
  int   fails;

  fetch_align_buffer_if bus ();

  fetch_align_buffer #(
    .RESET_PC(32'h0000_0000),
    .HW_DEPTH(4)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_word     = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.in_valid    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect    = 1'b0;
  endtask

  task automatic test_reset();
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL rst_valid got %b want 0", bus.out_valid); fails++;
    end
    cmp++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL rst_ready got %b want 1", bus.in_ready); fails++;
    end
    cmp++;
    if (bus.out_pc !== 32'h0) begin
      $display("FAIL rst_pc got %h want 0", bus.out_pc); fails++;
    end
    cmp++;
    if (bus.out_instr !== 32'h0) begin
      $display("FAIL rst_instr got %h want 0", bus.out_instr); fails++;
    end
    cmp++;
    if (bus.out_is_c !== 1'b0) begin
      $display("FAIL rst_is_c got %b want 0", bus.out_is_c); fails++;
    end
    cmp++;
  endtask

  task automatic test_two_words();
    do_redirect(32'h0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0001_4501;
    step();
    bus.in_valid  = 1'b0;
`ifdef FETCH_COMPRESSED_EN
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0000_4501) begin
      $display("FAIL two_c0 got %b/%h want 1/00004501",
               bus.out_valid, bus.out_instr); fails++;
    end
    cmp++;
    if (bus.out_is_c !== 1'b1 || bus.out_pc !== 32'h0) begin
      $display("FAIL two_c0_pc got %b/%h want 1/0",
               bus.out_is_c, bus.out_pc); fails++;
    end
    cmp++;
    step();
    if (bus.out_instr !== 32'h0000_0001 || bus.out_pc !== 32'h2) begin
      $display("FAIL two_c1 got %h@%h want 00000001@2",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    step();
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h4) begin
      $display("FAIL two_end got %b@%h want 0@4",
               bus.out_valid, bus.out_pc); fails++;
    end
    cmp++;
`else
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0001_4501) begin
      $display("FAIL w32_0 got %b/%h want 1/00014501",
               bus.out_valid, bus.out_instr); fails++;
    end
    cmp++;
    if (bus.out_is_c !== 1'b0 || bus.out_pc !== 32'h0) begin
      $display("FAIL w32_0_pc got %b/%h want 0/0",
               bus.out_is_c, bus.out_pc); fails++;
    end
    cmp++;
    step();
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h4) begin
      $display("FAIL w32_mid got %b@%h want 0@4",
               bus.out_valid, bus.out_pc); fails++;
    end
    cmp++;
    bus.in_valid = 1'b1;
    bus.in_word  = 32'h0010_0793;
    step();
    bus.in_valid = 1'b0;
    if (bus.out_instr !== 32'h0010_0793 || bus.out_pc !== 32'h4) begin
      $display("FAIL w32_1 got %h@%h want 00100793@4",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    step();
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h8) begin
      $display("FAIL w32_end got %b@%h want 0@8",
               bus.out_valid, bus.out_pc); fails++;
    end
    cmp++;
`endif
  endtask

  task automatic test_straddle();
    do_redirect(32'h0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0793_4505;
    step();
    bus.in_word   = 32'h0000_0010;
`ifdef FETCH_COMPRESSED_EN
    if (bus.out_instr !== 32'h0000_4505 || bus.out_is_c !== 1'b1) begin
      $display("FAIL strad_c got %h/%b want 00004505/1",
               bus.out_instr, bus.out_is_c); fails++;
    end
    cmp++;
    step();
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0010_0793) begin
      $display("FAIL strad_w got %b/%h want 1/00100793",
               bus.out_valid, bus.out_instr); fails++;
    end
    cmp++;
    if (bus.out_pc !== 32'h2 || bus.out_is_c !== 1'b0) begin
      $display("FAIL strad_pc got %h/%b want 2/0",
               bus.out_pc, bus.out_is_c); fails++;
    end
    cmp++;
`else
    if (bus.out_instr !== 32'h0793_4505 || bus.out_pc !== 32'h0) begin
      $display("FAIL b2b_0 got %h@%h want 07934505@0",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    step();
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0000_0010) begin
      $display("FAIL b2b_1 got %b/%h want 1/00000010",
               bus.out_valid, bus.out_instr); fails++;
    end
    cmp++;
    if (bus.out_pc !== 32'h4 || bus.out_is_c !== 1'b0) begin
      $display("FAIL b2b_pc got %h/%b want 4/0",
               bus.out_pc, bus.out_is_c); fails++;
    end
    cmp++;
`endif
    step();
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    do_redirect(32'h0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h1111_1111;
    step();
    bus.out_ready   = 1'b1;
    bus.in_word     = 32'h2222_2222;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    step();
    bus.redirect = 1'b0;
    bus.in_word  = 32'hFFFF_0513;
`ifdef FETCH_COMPRESSED_EN
    exp_pc = 32'h0000_0102;
`else
    exp_pc = 32'h0000_0100;
`endif
    if (bus.out_valid !== 1'b0 || bus.out_pc !== exp_pc) begin
      $display("FAIL redir_flush got %b@%h want 0@%h",
               bus.out_valid, bus.out_pc, exp_pc); fails++;
    end
    cmp++;
    step();
    bus.in_word = 32'h0000_0000;
`ifdef FETCH_COMPRESSED_EN
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL redir_half got %b want 0", bus.out_valid); fails++;
    end
    cmp++;
    step();
    bus.in_valid = 1'b0;
    if (bus.out_instr !== 32'h0000_FFFF || bus.out_pc !== 32'h102) begin
      $display("FAIL redir_w got %h@%h want 0000ffff@102",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_is_c !== 1'b0) begin
      $display("FAIL redir_v got %b/%b want 1/0",
               bus.out_valid, bus.out_is_c); fails++;
    end
    cmp++;
`else
    if (bus.out_instr !== 32'hFFFF_0513 || bus.out_pc !== 32'h100) begin
      $display("FAIL redir_w got %h@%h want ffff0513@100",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    step();
    bus.in_valid = 1'b0;
    if (bus.out_instr !== 32'h0 || bus.out_pc !== 32'h104
        || bus.out_valid !== 1'b1) begin
      $display("FAIL redir_w2 got %b/%h@%h want 1/0@104",
               bus.out_valid, bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
`endif
    step();
  endtask

  task automatic test_backpressure();
    do_redirect(32'h0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0000_0513;
    step();
    bus.in_word   = 32'h0010_0793;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL bp_ready2 got %b want 1", bus.in_ready); fails++;
    end
    cmp++;
    step();
    bus.in_word = 32'h0020_0813;
    for (int i = 0; i < 2; i++) begin
      if (bus.in_ready !== 1'b0) begin
        $display("FAIL bp_full%0d got %b want 0", i, bus.in_ready); fails++;
      end
      cmp++;
      if (bus.out_instr !== 32'h0000_0513 || bus.out_pc !== 32'h0) begin
        $display("FAIL bp_hold%0d got %h@%h want 00000513@0",
                 i, bus.out_instr, bus.out_pc); fails++;
      end
      cmp++;
      step();
    end
    bus.out_ready = 1'b1;
    step();
    if (bus.out_instr !== 32'h0010_0793 || bus.out_pc !== 32'h4) begin
      $display("FAIL bp_rel1 got %h@%h want 00100793@4",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL bp_ready_back got %b want 1", bus.in_ready); fails++;
    end
    cmp++;
    step();
    bus.in_valid = 1'b0;
    if (bus.out_instr !== 32'h0020_0813 || bus.out_pc !== 32'h8) begin
      $display("FAIL bp_rel2 got %h@%h want 00200813@8",
               bus.out_instr, bus.out_pc); fails++;
    end
    cmp++;
    step();
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'hC) begin
      $display("FAIL bp_empty got %b@%h want 0@c",
               bus.out_valid, bus.out_pc); fails++;
    end
    cmp++;
  endtask

  task automatic test_reset_mid();
    do_redirect(32'h0000_0040);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0000_0513;
    step();
    bus.in_valid  = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL mid_rst_vr got %b/%b want 0/1",
               bus.out_valid, bus.in_ready); fails++;
    end
    cmp++;
    if (bus.out_pc !== 32'h0) begin
      $display("FAIL mid_rst_pc got %h want 0", bus.out_pc); fails++;
    end
    cmp++;
    step();
    nrst = 1'b1;
    step();
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL mid_rst_after got %b want 0", bus.out_valid); fails++;
    end
    cmp++;
  endtask

  initial begin
    cmp   = 0;
    fails = 0;
    nrst  = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    #12;
    test_reset();
    nrst = 1'b1;
    step();
    test_reset();
    test_two_words();
    test_straddle();
    test_redirect();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/fetch_align_buffer.md
# fetch_align_buffer

- Sits between instruction memory and the controller's opcode/funct3/funct7 decode inputs.
- Accepts a stream of 32-bit memory words, splits them into halfwords and reassembles complete RV32IMC instructions, including 32-bit instructions that straddle a word boundary.
- Presents one aligned instruction per cycle with its PC and a compressed flag, under valid/ready on both sides.
- Discards buffered state on a control-flow redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first instruction after reset.
- `HW_DEPTH`, 4, halfword buffer capacity; even, ≥4.
- `clk`  in  1  sole clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  buffer can accept a word.
- `in_word`  in  32  memory word; the lower halfword is the earlier address.
- `out_valid`  out  1  `out_instr` holds a complete instruction.
- `out_ready`  in  1  decode consumes the instruction.
- `out_instr`  out  32  instruction; compressed instructions are zero-extended in [15:0].
- `out_pc`  out  32  PC of `out_instr`.
- `out_is_c`  out  1  `out_instr` is a 16-bit instruction.
- `redirect`  in  1  flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  new PC; bit 0 is ignored.

## Operation
- **Storage:** circular halfword FIFO of `HW_DEPTH` entries, with read pointer, write pointer and count of width clog2(`HW_DEPTH`)+1. Pointers wrap modulo `HW_DEPTH`.
- **Push:** occurs when `in_valid && in_ready`.
  - Two halfwords are written, low half first.
  - When the `skip` flag is set, the low half is dropped, only the high half is written, and `skip` clears.
- **`in_ready`:** equals count ≤ `HW_DEPTH`-2, evaluated on registered state only. It does not look at this cycle's pop.
- **Head classification:** head halfword[1:0] != 2'b11 means compressed; otherwise the instruction is 32 bits.
- **`out_valid`:** (compressed && count≥1) || (!compressed && count≥2).
  - For a 32-bit instruction, `out_instr` = {hw[rd+1], hw[rd]}.
- **Pop:** occurs when `out_valid && out_ready`.
  - Compressed: remove 1 halfword, `out_pc` += 2.
  - 32-bit: remove 2 halfwords, `out_pc` += 4.
- **Simultaneous push and pop:** count_next = count + pushed − popped.
- **Redirect:** highest priority.
  - Next cycle: count=0, pointers=0, `out_pc` = {`redirect_pc`[31:1],1'b0}, `skip` = `redirect_pc`[1].
  - Any push or pop in the redirect cycle is discarded.
- **Data responsibility:** the block does not check memory data. Upstream delivers words starting at `redirect_pc` & ~3 after a redirect.

## Timing
- **Reset values:** count=0, pointers=0, `skip`=0, `out_pc`=`RESET_PC`, `out_valid`=0, `in_ready`=1, `out_instr`=0, `out_is_c`=0.
- **Latency:** a word pushed in cycle N can produce `out_valid` in cycle N+1.
  - Output data is combinational from buffer state, not from `in_word`; there is no bypass.
- **Straddling 32-bit instruction:** lower half in the previous word's high half. `out_valid` rises in the cycle after the second word is pushed.
- **Full:** with count=`HW_DEPTH`-1, `in_ready`=0. It returns to 1 in the cycle after a pop lowers count to ≤`HW_DEPTH`-2.
- **Holding:** `out_valid` stays high and `out_instr`/`out_pc` stay stable while `out_ready`=0, unless a redirect occurs.
- **Reset mid-operation:** `nrst` low immediately forces the reset values, without waiting for a clock edge. Buffered data is lost.

## Configuration
- `FETCH_COMPRESSED_EN` defined: full RV32IMC behaviour as above.
- `FETCH_COMPRESSED_EN` undefined:
  - Every head is treated as 32-bit.
  - `out_is_c` is tied 0.
  - `out_valid` requires count≥2.
  - `redirect_pc`[1] is ignored (forced 0), so `skip` is never set.
  - `out_pc` always advances by 4.

## Test plan
- **Reset:** assert `nrst`=0 mid-run → `out_valid`=0, `in_ready`=1, `out_pc`=`RESET_PC` immediately, before the next edge.
- **Two compressed:** push 32'h0001_4501 with `out_ready`=1 → next cycle `out_instr`=32'h0000_4501, `out_is_c`=1, `out_pc`=0; following cycle 32'h0000_0001, `out_pc`=2.
- **Straddle:** push 32'h0793_4505, then 32'h0000_0010 → c.li at pc 0, then `out_instr`=32'h0010_0793 (addi) at pc 2 with `out_is_c`=0, valid one cycle after the second push.
- **Redirect mid-buffer:** redirect with `redirect_pc`=32'h0000_0102, then push 32'hFFFF_0513 and 32'h0000_0000 → the first low half is dropped; `out_instr`={16'h0000,16'hFFFF} at pc 0x102; prior contents are never output.
- **Backpressure/full:** hold `out_ready`=0 and push 2 words → `in_ready`=0 once count=4; the third word is not accepted; release `out_ready` → order and PCs are preserved.
- **`FETCH_COMPRESSED_EN` off:** push 32'h0001_4501 → 32-bit `out_instr`=32'h0001_4501, `out_is_c`=0, `out_pc` +4 per pop.
